filtered_ram_swap_control: RTL and testbench



---
 rtl/filtered_ram_swap_control_pkg.sv | 29 ++
 rtl/filtered_ram_swap_control_if.sv | 48 ++++
 rtl/filtered_ram_swap_control_bank.sv | 25 ++
 rtl/filtered_ram_swap_control.sv | 177 +++++++++++++++++
 tb/tb_filtered_ram_swap_control.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/filtered_ram_swap_control_pkg.sv
// Shared types and constants for the triple-bank filtered-projection RAM controller.
package nabp_fr_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int S_W_DEF         = 10;
  localparam int ANGLE_W_DEF     = 8;
  localparam int LINE_SIZE_DEF   = 512;
  localparam int NO_OF_BANKS_DEF = 3;

  typedef enum logic [2:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FILLED,
    BANK_CURRENT,
    BANK_PREVIOUS
  } bank_state_t;

  typedef logic [1:0] bank_idx_t;

  // s values are centred on the middle of a line
  function automatic int s_to_addr_offset(input int line_size);
    return line_size / 2;
  endfunction

  function automatic bank_idx_t next_bank(input bank_idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/filtered_ram_swap_control_if.sv
// Filter-write and processing-read bundle; fr_err exists only with FILTERED_RAM_ERR_EN.
interface filtered_ram_swap_control_if
  import nabp_fr_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int S_W     = S_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF
);
  logic                      fw_valid;
  logic                      fw_ready;
  logic [DATA_W-1:0]         fw_val;
  logic [ANGLE_W-1:0]        fw_angle;
  logic                      fw_has_more;
  logic [ANGLE_W-1:0]        fr_angle;
  logic                      fr_has_next_angle;
  logic                      fr_next_angle;
  logic                      fr_next_angle_ack;
  logic                      fr_prev_angle_release;
  logic                      fr_prev_angle_release_ack;
  logic signed [S_W-1:0]     fr0_s_val;
  logic signed [S_W-1:0]     fr1_s_val;
  logic signed [DATA_W-1:0]  fr0_val;
  logic signed [DATA_W-1:0]  fr1_val;
`ifdef FILTERED_RAM_ERR_EN
  logic [3:0]                fr_err;
`endif

  modport master (
    output fw_valid, fw_val, fw_angle, fw_has_more,
    output fr_next_angle, fr_prev_angle_release, fr0_s_val, fr1_s_val,
    input  fw_ready, fr_angle, fr_has_next_angle, fr_next_angle_ack,
    input  fr_prev_angle_release_ack, fr0_val, fr1_val
`ifdef FILTERED_RAM_ERR_EN
    , input fr_err
`endif
  );

  modport slave (
    input  fw_valid, fw_val, fw_angle, fw_has_more,
    input  fr_next_angle, fr_prev_angle_release, fr0_s_val, fr1_s_val,
    output fw_ready, fr_angle, fr_has_next_angle, fr_next_angle_ack,
    output fr_prev_angle_release_ack, fr0_val, fr1_val
`ifdef FILTERED_RAM_ERR_EN
    , output fr_err
`endif
  );

endinterface

// File: rtl/filtered_ram_swap_control_bank.sv
// One filtered-line RAM: single write port, two independent registered read ports.
module filtered_ram_bank #(
  parameter int DATA_W    = 16,
  parameter int LINE_SIZE = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [LINE_SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
  end

endmodule

// File: rtl/filtered_ram_swap_control.sv
// Triple-bank filtered RAM swap controller; bank roles rotate FREE->FILLING->FILLED->CURRENT->PREVIOUS.
// Optional sticky protocol-error flags on fr_err when FILTERED_RAM_ERR_EN is defined.
module filtered_ram_swap_control
  import nabp_fr_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int S_W         = S_W_DEF,
  parameter int ANGLE_W     = ANGLE_W_DEF,
  parameter int LINE_SIZE   = LINE_SIZE_DEF,
  parameter int NO_OF_BANKS = NO_OF_BANKS_DEF
) (
  input logic                         clk,
  input logic                         reset_n,
  filtered_ram_swap_control_if.slave  bus
);

  localparam int ADDR_W   = $clog2(LINE_SIZE);
  localparam int XW       = S_W + 2;
  localparam int S_OFFSET = s_to_addr_offset(LINE_SIZE);

  if (NO_OF_BANKS != 3) begin : g_bad_banks
    $error("filtered_ram_swap_control supports exactly 3 banks");
  end
  if (LINE_SIZE > (2 ** (S_W - 1)) * 2) begin : g_bad_line
    $error("LINE_SIZE exceeds the addressable s range");
  end

  bank_state_t        state [NO_OF_BANKS];
  logic [ANGLE_W-1:0] tag   [NO_OF_BANKS];
  bank_idx_t          wr_ptr, cur_ptr, prev_ptr, head_ptr;
  logic               cur_held, prev_held;
  logic [ADDR_W-1:0]  fill_cnt;
  logic [ANGLE_W-1:0] fr_angle_q;

  logic filled_avail, fw_accept, next_ack, release_ack;

  always_comb begin
    filled_avail = 1'b0;
    for (int i = 0; i < NO_OF_BANKS; i++)
      if (state[i] == BANK_FILLED) filled_avail = 1'b1;
  end

  assign bus.fw_ready = reset_n && (state[wr_ptr] == BANK_FREE || state[wr_ptr] == BANK_FILLING);
  assign fw_accept    = bus.fw_valid && bus.fw_ready;

  // Release wins a collision; next_angle cannot displace a still-held PREVIOUS bank
  assign release_ack = reset_n && bus.fr_prev_angle_release && (prev_held || filled_avail);
  assign next_ack    = reset_n && bus.fr_next_angle && filled_avail && !prev_held
                       && !bus.fr_prev_angle_release;

  assign bus.fr_next_angle_ack         = next_ack;
  assign bus.fr_prev_angle_release_ack = release_ack;
  assign bus.fr_has_next_angle         = filled_avail || bus.fw_has_more;
  assign bus.fr_angle                  = fr_angle_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NO_OF_BANKS; i++) begin
        state[i] <= BANK_FREE;
        tag[i]   <= '0;
      end
      wr_ptr     <= '0;
      cur_ptr    <= '0;
      prev_ptr   <= '0;
      head_ptr   <= '0;
      cur_held   <= 1'b0;
      prev_held  <= 1'b0;
      fill_cnt   <= '0;
      fr_angle_q <= '0;
    end else begin
      if (fw_accept) begin
        if (fill_cnt == '0) begin
          state[wr_ptr] <= BANK_FILLING;
          tag[wr_ptr]   <= bus.fw_angle;
        end
        if (fill_cnt == ADDR_W'(LINE_SIZE - 1)) begin
          state[wr_ptr] <= BANK_FILLED;
          wr_ptr        <= next_bank(wr_ptr);
          fill_cnt      <= '0;
        end else begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
        end
      end

      // head_ptr always names the oldest FILLED bank because fills and promotions share the rotation
      if (release_ack && prev_held) begin
        state[prev_ptr] <= BANK_FREE;
        prev_held       <= 1'b0;
      end else if (release_ack || next_ack) begin
        if (cur_held) begin
          if (release_ack) begin
            state[cur_ptr] <= BANK_FREE;
          end else begin
            state[cur_ptr] <= BANK_PREVIOUS;
            prev_ptr       <= cur_ptr;
            prev_held      <= 1'b1;
          end
        end
        state[head_ptr] <= BANK_CURRENT;
        cur_ptr         <= head_ptr;
        cur_held        <= 1'b1;
        head_ptr        <= next_bank(head_ptr);
        fr_angle_q      <= tag[head_ptr];
      end
    end
  end

  logic signed [XW-1:0] addr0_ext, addr1_ext;
  logic                 in0, in1;

  assign addr0_ext = XW'(bus.fr0_s_val) + XW'(S_OFFSET);
  assign addr1_ext = XW'(bus.fr1_s_val) + XW'(S_OFFSET);
  assign in0       = !addr0_ext[XW-1] && (addr0_ext < XW'(LINE_SIZE));
  assign in1       = !addr1_ext[XW-1] && (addr1_ext < XW'(LINE_SIZE));

  logic [DATA_W-1:0] bank_rd0 [NO_OF_BANKS];
  logic [DATA_W-1:0] bank_rd1 [NO_OF_BANKS];

  for (genvar b = 0; b < NO_OF_BANKS; b++) begin : g_bank
    filtered_ram_bank #(
      .DATA_W    (DATA_W),
      .LINE_SIZE (LINE_SIZE),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk    (clk),
      .we     (fw_accept && (wr_ptr == bank_idx_t'(b))),
      .waddr  (fill_cnt),
      .wdata  (bus.fw_val),
      .raddr0 (addr0_ext[ADDR_W-1:0]),
      .raddr1 (addr1_ext[ADDR_W-1:0]),
      .rdata0 (bank_rd0[b]),
      .rdata1 (bank_rd1[b])
    );
  end

  // Bank selection is captured alongside the address so data follows the mapping of the request cycle
  bank_idx_t rd0_sel, rd1_sel;
  logic      rd0_valid, rd1_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd0_sel   <= '0;
      rd1_sel   <= '0;
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
    end else begin
      rd0_sel   <= cur_ptr;
      rd1_sel   <= prev_held ? prev_ptr : cur_ptr;
      rd0_valid <= cur_held && in0;
      rd1_valid <= (prev_held || cur_held) && in1;
    end
  end

  assign bus.fr0_val = rd0_valid ? bank_rd0[rd0_sel] : '0;
  assign bus.fr1_val = rd1_valid ? bank_rd1[rd1_sel] : '0;

`ifdef FILTERED_RAM_ERR_EN
  logic [3:0] err;
  logic       miss;

  assign miss = (bus.fr0_s_val != '0 && !in0) || (bus.fr1_s_val != '0 && !in1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= '0;
    end else begin
      err <= err | {miss,
                    bus.fr_next_angle && bus.fr_prev_angle_release,
                    bus.fr_next_angle && !bus.fr_has_next_angle,
                    bus.fw_valid && !bus.fw_ready};
    end
  end

  assign bus.fr_err = err;
`endif

endmodule

// File: tb/tb_filtered_ram_swap_control.sv
// Directed self-checking bench for filtered_ram_swap_control (fr_err checks under FILTERED_RAM_ERR_EN).
module tb_filtered_ram_swap_control;
  import nabp_fr_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   assertions = 0;
  int   failures   = 0;

  always #5 clk = ~clk;

  filtered_ram_swap_control_if bus ();

  filtered_ram_swap_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.fw_valid              = 1'b0;
    bus.fw_val                = '0;
    bus.fw_angle              = '0;
    bus.fw_has_more           = 1'b0;
    bus.fr_next_angle         = 1'b0;
    bus.fr_prev_angle_release = 1'b0;
    bus.fr0_s_val             = '0;
    bus.fr1_s_val             = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    bus.fw_has_more = 1'b1;
    reset_n = 1'b1;
  endtask

  // Streams n samples of one line, value = base + address
  task automatic applyStimulus(input int angle, input int n, input int base);
    int waited;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fw_valid = 1'b1;
      bus.fw_val   = 16'(base + i);
      bus.fw_angle = 8'(angle);
      #1;
      waited = 0;
      while (!bus.fw_ready && waited < 100) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (waited >= 100) begin
        checkOutput("fw_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.fw_valid = 1'b0;
  endtask

  task automatic pulseRequest(input string tag, input logic nxt, input logic rel,
                              input logic exp_next, input logic exp_rel);
    @(negedge clk);
    bus.fr_next_angle         = nxt;
    bus.fr_prev_angle_release = rel;
    #1;
    checkOutput({tag, "_next_ack"}, bus.fr_next_angle_ack, exp_next);
    checkOutput({tag, "_rel_ack"}, bus.fr_prev_angle_release_ack, exp_rel);
    @(posedge clk);
    @(negedge clk);
    bus.fr_next_angle         = 1'b0;
    bus.fr_prev_angle_release = 1'b0;
  endtask

  task automatic readCheck(input string tag, input int s0, input int exp0,
                           input int s1, input int exp1);
    @(negedge clk);
    bus.fr0_s_val = 10'(s0);
    bus.fr1_s_val = 10'(s1);
    @(posedge clk);
    #1;
    checkOutput({tag, "_p0"}, bus.fr0_val, exp0);
    checkOutput({tag, "_p1"}, bus.fr1_val, exp1);
    @(negedge clk);
    bus.fr0_s_val = '0;
    bus.fr1_s_val = '0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    bus.fw_valid              = 1'b1;
    bus.fw_has_more           = 1'b1;
    bus.fr_next_angle         = 1'b1;
    bus.fr_prev_angle_release = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_fw_ready", bus.fw_ready, 0);
    checkOutput("rst_next_ack", bus.fr_next_angle_ack, 0);
    checkOutput("rst_rel_ack", bus.fr_prev_angle_release_ack, 0);
    checkOutput("rst_fr_angle", bus.fr_angle, 0);
    checkOutput("rst_fr0_val", bus.fr0_val, 0);
    checkOutput("rst_fr1_val", bus.fr1_val, 0);
    idle();
    bus.fw_has_more = 1'b1;
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_fw_ready", bus.fw_ready, 1);
    checkOutput("post_rst_has_next", bus.fr_has_next_angle, 1);

    // Test 1: single line, release loads it, address-window edges
    applyStimulus(5, 512, 0);
    #1;
    checkOutput("t1_ready_after_line", bus.fw_ready, 1);
    @(negedge clk);
    bus.fr_prev_angle_release = 1'b1;
    #1;
    checkOutput("t1_rel_ack", bus.fr_prev_angle_release_ack, 1);
    checkOutput("t1_next_ack", bus.fr_next_angle_ack, 0);
    checkOutput("t1_angle_before", bus.fr_angle, 0);
    @(posedge clk);
    #1;
    checkOutput("t1_angle_after", bus.fr_angle, 5);
    @(negedge clk);
    bus.fr_prev_angle_release = 1'b0;
    readCheck("t1_sm256", -256, 0, 10, 266);
    readCheck("t1_s255", 255, 511, 0, 256);
    readCheck("t1_s256", 256, 0, -257, 0);

    // Test 2: three lines, rotation through CURRENT and PREVIOUS
    doReset();
    applyStimulus(1, 512, 1000);
    applyStimulus(2, 512, 2000);
    applyStimulus(3, 512, 3000);
    #1;
    checkOutput("t2_ready_full", bus.fw_ready, 0);
    pulseRequest("t2_rel", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_angle1", bus.fr_angle, 1);
    readCheck("t2_cur1", 0, 1256, 0, 1256);
    pulseRequest("t2_next", 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_angle2", bus.fr_angle, 2);
    readCheck("t2_split", 0, 2256, 5, 1261);
    pulseRequest("t2_next_blocked", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_angle_hold", bus.fr_angle, 2);
    #1;
    checkOutput("t2_ready_prev_held", bus.fw_ready, 0);
    pulseRequest("t2_rel_prev", 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("t2_ready_freed", bus.fw_ready, 1);
    readCheck("t2_p1_cur", 0, 2256, 5, 2261);

    // Test 3: next_angle waits for a line, grant one cycle after it is FILLED
    doReset();
    applyStimulus(7, 512, 0);
    pulseRequest("t3_rel", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_angle7", bus.fr_angle, 7);
    @(negedge clk);
    bus.fr_next_angle = 1'b1;
    #1;
    checkOutput("t3_wait_ack", bus.fr_next_angle_ack, 0);
    applyStimulus(8, 511, 100);
    #1;
    checkOutput("t3_wait_ack_partial", bus.fr_next_angle_ack, 0);
    @(negedge clk);
    bus.fw_valid = 1'b1;
    bus.fw_val   = 16'd611;
    bus.fw_angle = 8'd8;
    #1;
    checkOutput("t3_complete_ready", bus.fw_ready, 1);
    checkOutput("t3_complete_ack", bus.fr_next_angle_ack, 0);
    @(posedge clk);
    @(negedge clk);
    bus.fw_valid = 1'b0;
    #1;
    checkOutput("t3_filled_ack", bus.fr_next_angle_ack, 1);
    checkOutput("t3_angle_still7", bus.fr_angle, 7);
    @(posedge clk);
    @(negedge clk);
    bus.fr_next_angle = 1'b0;
    checkOutput("t3_angle8", bus.fr_angle, 8);
    readCheck("t3_split", 0, 356, 0, 256);

    // Test 4: frame end, release stalls until a new line lands
    @(negedge clk);
    bus.fw_has_more = 1'b0;
    #1;
    checkOutput("t4_has_next", bus.fr_has_next_angle, 0);
    pulseRequest("t4_rel_prev", 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.fr_prev_angle_release = 1'b1;
    #1;
    checkOutput("t4_rel_stall", bus.fr_prev_angle_release_ack, 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t4_rel_stall_later", bus.fr_prev_angle_release_ack, 0);
    applyStimulus(9, 512, 200);
    #1;
    checkOutput("t4_has_next_filled", bus.fr_has_next_angle, 1);
    checkOutput("t4_rel_granted", bus.fr_prev_angle_release_ack, 1);
    checkOutput("t4_angle_still8", bus.fr_angle, 8);
    @(posedge clk);
    @(negedge clk);
    bus.fr_prev_angle_release = 1'b0;
    checkOutput("t4_angle9", bus.fr_angle, 9);
    readCheck("t4_cur", -1, 455, -1, 455);

    // Test 5: reset in the middle of a fill
    @(negedge clk);
    bus.fw_has_more = 1'b1;
    applyStimulus(11, 100, 500);
    @(negedge clk);
    reset_n                   = 1'b0;
    bus.fw_valid              = 1'b1;
    bus.fr_next_angle         = 1'b1;
    bus.fr_prev_angle_release = 1'b1;
    #1;
    checkOutput("t5_rst_ready", bus.fw_ready, 0);
    checkOutput("t5_rst_next_ack", bus.fr_next_angle_ack, 0);
    checkOutput("t5_rst_rel_ack", bus.fr_prev_angle_release_ack, 0);
    @(posedge clk);
    #1;
    checkOutput("t5_rst_fr0", bus.fr0_val, 0);
    checkOutput("t5_rst_angle", bus.fr_angle, 0);
    @(negedge clk);
    idle();
    bus.fw_has_more = 1'b1;
    reset_n = 1'b1;
    applyStimulus(12, 512, 600);
    pulseRequest("t5_rel", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_angle12", bus.fr_angle, 12);
    readCheck("t5_refill", -256, 600, 255, 1111);

    // Test 6: simultaneous requests, release has priority
    applyStimulus(13, 512, 0);
    pulseRequest("t6_collide", 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t6_angle13", bus.fr_angle, 13);
`ifdef FILTERED_RAM_ERR_EN
    checkOutput("t6_err2", bus.fr_err[2], 1);
    repeat (2) @(negedge clk);
    checkOutput("t6_err2_sticky", bus.fr_err[2], 1);
    doReset();
    #1;
    checkOutput("t6_err_cleared", bus.fr_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
